// File: rtl/op_seq_pkg.sv
// Shared types and helpers for the operand sequencer and its result FIFO.
package op_seq_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  // Next address in a window that wraps at depth-1; depth need not be a power of two.
  function automatic int unsigned wrap_inc(input int unsigned addr, input int unsigned depth);
    if (addr == depth - 1) return 0;
    return addr + 1;
  endfunction

endpackage

// File: rtl/op_seq_ctrl_fifo.sv
// Two-entry FIFO holding {address, result} pairs on their way to the result memory.
module seq_result_fifo #(
  parameter int AW = 3,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          valid,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic [1:0]    occupancy
);

  logic [AW+DW-1:0] entries [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       cnt;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = pop && (cnt != 2'd0);
  assign do_push = push && ((cnt != 2'd2) || do_pop);

  // Storage, pointers and occupancy; a simultaneous push and pop leaves occupancy unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries[0] <= '0;
      entries[1] <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      cnt        <= 2'd0;
    end else begin
      if (do_push) begin
        entries[wr_ptr] <= {push_addr, push_data};
        wr_ptr          <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt <= cnt + 2'(do_push) - 2'(do_pop);
    end
  end

  assign valid                  = (cnt != 2'd0);
  assign {head_addr, head_data} = entries[rd_ptr];
  assign occupancy              = cnt;

endmodule

// File: rtl/op_seq_ctrl.sv
// Start/busy/done sequencer: reads operand pairs over a wrapping address window,
// applies the latched operation and streams results out through a 2-entry FIFO.
module op_seq_ctrl
  import op_seq_pkg::*;
#(
  parameter  int MEM_DEPTH = 8,
  parameter  int MEM_WIDTH = 32,
  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1,
  localparam int CW = $clog2(MEM_DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [AW-1:0]        base_addr_i,
  input  logic [CW-1:0]        count_i,
  input  logic [1:0]           op_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 rd_en_o,
  output logic [AW-1:0]        rd_addr_o,
  input  logic [MEM_WIDTH-1:0] operand1_i,
  input  logic [MEM_WIDTH-1:0] operand2_i,
  output logic                 wr_valid_o,
  input  logic                 wr_ready_i,
  output logic [AW-1:0]        wr_addr_o,
  output logic [MEM_WIDTH-1:0] wr_data_o
);

  state_e               state;
  op_e                  op_q;
  logic [CW-1:0]        count_q;
  logic [CW-1:0]        count_clamped;
  logic [CW-1:0]        issued;
  logic [CW-1:0]        written;
  logic [CW-1:0]        written_next;
  logic [AW-1:0]        addr_q;
  logic [AW-1:0]        inflight_addr;
  logic                 inflight;
  logic [1:0]           occupancy;
  logic                 pop;
  logic                 rd_en;
  logic                 can_issue;
  logic [2:0]           credit_sum;
  logic [MEM_WIDTH-1:0] result;

  assign count_clamped = (count_i > CW'(MEM_DEPTH)) ? CW'(MEM_DEPTH) : count_i;
  assign pop           = wr_valid_o && wr_ready_i;
  assign written_next  = written + CW'(pop);

  // Reads in flight plus queued results must stay below two once this cycle's pop is counted,
  // so the FIFO can never overflow.
  assign credit_sum = 3'(occupancy) + 3'(inflight);
  assign can_issue  = credit_sum < (3'd2 + 3'(pop));
  assign rd_en      = (state == RUN) && (issued < count_q) && can_issue;

  assign rd_en_o   = rd_en;
  assign rd_addr_o = addr_q;
  assign busy_o    = (state != IDLE);
  assign done_o    = (state == DONE);

  // Control FSM: latches the request at start, walks the address window, then waits for the last write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      op_q    <= OP_ADD;
      count_q <= '0;
      issued  <= '0;
      written <= '0;
      addr_q  <= '0;
    end else begin
      if (pop) begin
        written <= written_next;
      end
      unique case (state)
        IDLE: begin
          if (start_i) begin
            op_q    <= op_e'(op_i);
            count_q <= count_clamped;
            addr_q  <= base_addr_i;
            issued  <= '0;
            written <= '0;
            state   <= (count_clamped == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (rd_en) begin
            issued <= issued + CW'(1);
            addr_q <= AW'(wrap_inc(32'(addr_q), 32'(MEM_DEPTH)));
            if ((issued + CW'(1)) == count_q) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if ((written_next == count_q) && !inflight) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Tracks the single read whose operands arrive next cycle, along with its address.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight      <= 1'b0;
      inflight_addr <= '0;
    end else begin
      inflight      <= rd_en;
      inflight_addr <= addr_q;
    end
  end

  // Result of the latched operation on the operand pair currently on the read bus.
  always_comb begin
    result = '0;
    case (op_q)
      OP_ADD:  result = operand1_i + operand2_i;
      OP_SUB:  result = operand1_i - operand2_i;
      OP_AND:  result = operand1_i & operand2_i;
      OP_XOR:  result = operand1_i ^ operand2_i;
      default: result = '0;
    endcase
  end

  seq_result_fifo #(
    .AW(AW),
    .DW(MEM_WIDTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .push      (inflight),
    .push_addr (inflight_addr),
    .push_data (result),
    .pop       (pop),
    .valid     (wr_valid_o),
    .head_addr (wr_addr_o),
    .head_data (wr_data_o),
    .occupancy (occupancy)
  );

endmodule

// File: tb/tb_op_seq_ctrl.sv
// Self-checking bench for op_seq_ctrl: operand memory model, reference model and write scoreboard.
module tb_op_seq_ctrl;

  localparam int MEM_DEPTH = 8;
  localparam int MEM_WIDTH = 32;
  localparam int AW = 3;
  localparam int CW = 4;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 start_i = 1'b0;
  logic [AW-1:0]        base_addr_i = '0;
  logic [CW-1:0]        count_i = '0;
  logic [1:0]           op_i = '0;
  logic                 busy_o;
  logic                 done_o;
  logic                 rd_en_o;
  logic [AW-1:0]        rd_addr_o;
  logic [MEM_WIDTH-1:0] operand1_i = '0;
  logic [MEM_WIDTH-1:0] operand2_i = '0;
  logic                 wr_valid_o;
  logic                 wr_ready_i = 1'b1;
  logic [AW-1:0]        wr_addr_o;
  logic [MEM_WIDTH-1:0] wr_data_o;

  op_seq_ctrl #(
    .MEM_DEPTH(MEM_DEPTH),
    .MEM_WIDTH(MEM_WIDTH)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .count_i     (count_i),
    .op_i        (op_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .rd_en_o     (rd_en_o),
    .rd_addr_o   (rd_addr_o),
    .operand1_i  (operand1_i),
    .operand2_i  (operand2_i),
    .wr_valid_o  (wr_valid_o),
    .wr_ready_i  (wr_ready_i),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o)
  );

  always #5 clk_i = ~clk_i;

  logic [MEM_WIDTH-1:0]    mem1 [MEM_DEPTH];
  logic [MEM_WIDTH-1:0]    mem2 [MEM_DEPTH];
  logic [AW+MEM_WIDTH-1:0] exp_q [$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = 0;
  int ready_mode = 0;
  int reads, writes, done_seen, done_k, first_wr_k, first_rd_k, last_rd_k, max_out, busy_at_done;
  int mon_k;
  int rdy_k;
  logic [AW+MEM_WIDTH-1:0] head;

  // Free-running cycle counter used to time events relative to the start edge.
  always @(posedge clk_i) cyc <= cyc + 1;

  // Operand memories with one-cycle read latency; garbage on cycles without a read.
  always @(posedge clk_i) begin
    if (rd_en_o) begin
      operand1_i <= mem1[rd_addr_o];
      operand2_i <= mem2[rd_addr_o];
    end else begin
      operand1_i <= $urandom;
      operand2_i <= $urandom;
    end
  end

  function automatic logic [MEM_WIDTH-1:0] refOp(input int op, input logic [MEM_WIDTH-1:0] a,
                                                input logic [MEM_WIDTH-1:0] b);
    case (op)
      0:       return a + b;
      1:       return a - b;
      2:       return a & b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Result-memory backpressure: always ready, a fixed stall window, or random stalls.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      rdy_k = cyc - start_cyc + 1;
      case (ready_mode)
        1:       wr_ready_i = !(rdy_k >= 3 && rdy_k <= 7);
        2:       wr_ready_i = ($urandom_range(0, 3) != 0);
        default: wr_ready_i = 1'b1;
      endcase
    end
  end

  // Monitor: compares every presented write against the scoreboard head, pops on transfer.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      mon_k = cyc - start_cyc + 1;
      if (rd_en_o) begin
        reads++;
        if (first_rd_k < 0) first_rd_k = mon_k;
        last_rd_k = mon_k;
      end
      if (wr_valid_o) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_wr_valid", 64'(wr_valid_o), 64'd0);
        end else begin
          head = exp_q[0];
          checkOutput("wr_addr", 64'(wr_addr_o), 64'(head[AW+MEM_WIDTH-1:MEM_WIDTH]));
          checkOutput("wr_data", 64'(wr_data_o), 64'(head[MEM_WIDTH-1:0]));
          if (wr_ready_i) begin
            void'(exp_q.pop_front());
            writes++;
            if (first_wr_k < 0) first_wr_k = mon_k;
          end
        end
      end
      if (reads - writes > max_out) max_out = reads - writes;
      if (done_o) begin
        done_seen++;
        done_k       = mon_k;
        busy_at_done = int'(busy_o);
      end
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"},     64'(busy_o),     64'd0);
    checkOutput({tag, "_done"},     64'(done_o),     64'd0);
    checkOutput({tag, "_rd_en"},    64'(rd_en_o),    64'd0);
    checkOutput({tag, "_rd_addr"},  64'(rd_addr_o),  64'd0);
    checkOutput({tag, "_wr_valid"}, 64'(wr_valid_o), 64'd0);
    checkOutput({tag, "_wr_addr"},  64'(wr_addr_o),  64'd0);
    checkOutput({tag, "_wr_data"},  64'(wr_data_o),  64'd0);
  endtask

  // One run: load memories, predict writes, pulse start, optionally misuse start or abort with reset.
  task automatic applyStimulus(input int base, input int cnt, input int op,
                               input logic [MEM_WIDTH-1:0] v1, input logic [MEM_WIDTH-1:0] v2,
                               input bit fixed, input int rmode, input int abort_k, input int misuse_k);
    int n;
    int k;
    bit finished;
    logic [AW-1:0] a;
    n = (cnt > MEM_DEPTH) ? MEM_DEPTH : cnt;
    for (int i = 0; i < MEM_DEPTH; i++) begin
      mem1[i] = fixed ? v1 : $urandom;
      mem2[i] = fixed ? v2 : $urandom;
    end
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      a = AW'((base + i) % MEM_DEPTH);
      exp_q.push_back({a, refOp(op, mem1[a], mem2[a])});
    end
    reads = 0; writes = 0; done_seen = 0; done_k = -1;
    first_wr_k = -1; first_rd_k = -1; last_rd_k = -1; max_out = 0; busy_at_done = 0;
    ready_mode = rmode;
    @(posedge clk_i);
    #1;
    base_addr_i = AW'(base);
    count_i     = CW'(cnt);
    op_i        = 2'(op);
    start_i     = 1'b1;
    start_cyc   = cyc + 1;
    @(posedge clk_i);
    #1;
    start_i  = 1'b0;
    finished = 0;
    for (int c = 0; c < 300 && !finished; c++) begin
      k = cyc - start_cyc + 1;
      if (misuse_k != 0 && k == misuse_k) begin
        start_i     = 1'b1;
        count_i     = CW'(2);
        op_i        = 2'(op ^ 1);
        base_addr_i = AW'(base + 3);
      end else begin
        start_i = 1'b0;
      end
      if (abort_k != 0 && k == abort_k) begin
        #2;
        rst_ni = 1'b0;
        #1;
        checkResetOutputs("abort");
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni   = 1'b1;
        finished = 1;
      end else begin
        if (done_seen > 0 && k == done_k + 1) checkOutput("busy_after_done", 64'(busy_o), 64'd0);
        if (done_seen > 0 && k >= done_k + 2) finished = 1;
        else begin
          @(posedge clk_i);
          #1;
        end
      end
    end
    start_i = 1'b0;
    if (!finished) checkOutput("done_timeout", 64'd0, 64'd1);
    if (abort_k != 0) begin
      checkOutput("abort_no_done", 64'(done_seen), 64'd0);
    end else begin
      checkOutput("done_pulses", 64'(done_seen), 64'd1);
      checkOutput("busy_at_done", 64'(busy_at_done), 64'd1);
      checkOutput("write_count", 64'(writes), 64'(n));
      checkOutput("read_count", 64'(reads), 64'(n));
      checkOutput("pending_writes", 64'(exp_q.size()), 64'd0);
      checkOutput("max_outstanding_le2", 64'(max_out <= 2), 64'd1);
      if (rmode == 0) begin
        checkOutput("done_cycle", 64'(done_k), 64'((n == 0) ? 1 : n + 3));
        if (n > 0) begin
          checkOutput("first_rd_cycle", 64'(first_rd_k), 64'd1);
          checkOutput("last_rd_cycle", 64'(last_rd_k), 64'(n));
          checkOutput("first_wr_cycle", 64'(first_wr_k), 64'd3);
        end
      end
    end
    exp_q.delete();
    ready_mode = 0;
  endtask

  // Directed scenarios followed by randomized runs under random backpressure.
  initial begin
    #1;
    checkResetOutputs("reset");
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    $display("[TB] basic add");
    applyStimulus(0, 8, 0, 32'd3, 32'd4, 1'b1, 0, 0, 0);
    $display("[TB] wrap and sub");
    applyStimulus(6, 4, 1, 32'd5, 32'd9, 1'b1, 0, 0, 0);
    $display("[TB] zero count");
    applyStimulus(2, 0, 0, 32'd1, 32'd1, 1'b1, 0, 0, 0);
    $display("[TB] clamped count");
    applyStimulus(5, 12, 3, 32'd0, 32'd0, 1'b0, 0, 0, 0);
    $display("[TB] backpressure");
    applyStimulus(1, 8, 0, 32'd0, 32'd0, 1'b0, 1, 0, 0);
    $display("[TB] boundary data");
    applyStimulus(3, 2, 0, 32'hFFFF_FFFF, 32'd1, 1'b1, 0, 0, 0);
    applyStimulus(3, 2, 3, 32'hFFFF_FFFF, 32'd1, 1'b1, 0, 0, 0);
    applyStimulus(3, 2, 2, 32'hFFFF_FFFF, 32'd1, 1'b1, 0, 0, 0);
    $display("[TB] reset mid-run");
    applyStimulus(0, 8, 1, 32'd0, 32'd0, 1'b0, 0, 4, 0);
    applyStimulus(4, 6, 2, 32'd0, 32'd0, 1'b0, 0, 0, 0);
    $display("[TB] start ignored while busy");
    applyStimulus(7, 5, 0, 32'd0, 32'd0, 1'b0, 0, 0, 3);
    $display("[TB] random runs");
    for (int r = 0; r < 12; r++) begin
      applyStimulus($urandom_range(0, 7), $urandom_range(0, 12), $urandom_range(0, 3),
                    32'd0, 32'd0, 1'b0, 2, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/op_seq_ctrl.md
Name: op_seq_ctrl

Overview:
- Sequencer for the two-operand arithmetic datapath.
- On a start pulse it walks a window of operand memory addresses and issues reads to both operand memories on a shared address.
- It computes the selected operation on the returned operand pair and streams each result with its address to the result memory over a valid/ready write port.
- It sits between the operand memories and result_mem, replacing free-running address counters with a start/busy/done-controlled, backpressure-safe controller.

Parameters:
- MEM_DEPTH, 8: words per operand/result memory; need not be a power of two.
- MEM_WIDTH, 32: data width of operands and results.
- AW, $clog2(MEM_DEPTH): address width (derived localparam).
- CW, $clog2(MEM_DEPTH+1): width of the count field (derived localparam).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous assertion, active-low.
- start_i  in  1  begin a run; sampled only in IDLE.
- base_addr_i  in  AW  first element address; latched at start.
- count_i  in  CW  number of elements; latched at start; values above MEM_DEPTH clamp to MEM_DEPTH.
- op_i  in  2  operation select: 00 add, 01 sub (op1-op2), 10 and, 11 xor; latched at start.
- busy_o  out  1  high in RUN, DRAIN and DONE.
- done_o  out  1  one-cycle pulse at the end of a run.
- rd_en_o  out  1  operand read strobe.
- rd_addr_o  out  AW  shared operand read address.
- operand1_i  in  MEM_WIDTH  operand 1; valid one cycle after rd_en_o.
- operand2_i  in  MEM_WIDTH  operand 2; valid one cycle after rd_en_o.
- wr_valid_o  out  1  result write request.
- wr_ready_i  in  1  result memory accepts the write this cycle.
- wr_addr_o  out  AW  result address.
- wr_data_o  out  MEM_WIDTH  result data.

Behaviour:
- Reset:
  - The state machine enters IDLE.
  - All outputs are 0, internal counters are 0 and the FIFO is empty.
  - Reset asserted mid-run aborts the run immediately; no done_o pulse is produced.
- State IDLE:
  - start_i=1 with clamped count=0: go to DONE.
  - start_i=1 with clamped count>0: go to RUN.
  - Otherwise stay in IDLE.
- State RUN:
  - Issue a read (rd_en_o=1) when issued<count and credit is available.
  - Credit rule: fifo_occupancy + inflight - pop_this_cycle < 2.
  - rd_addr_o = base + issued index, wrapping from MEM_DEPTH-1 to 0 by explicit compare, not by truncation.
  - Go to DRAIN in the cycle after the last read is issued.
- State DRAIN:
  - No reads are issued.
  - Go to DONE when written==count, the FIFO is empty and nothing is in flight.
- State DONE:
  - done_o=1 for exactly one cycle, then IDLE.
  - busy_o is still 1 in DONE.
- start_i while busy_o=1 is ignored; no queuing.
- Read latency is fixed at 1:
  - The operand pair is valid in the cycle after rd_en_o.
  - The result is computed combinationally from operands and latched op.
  - The {addr, data} pair is pushed into a 2-entry FIFO at the end of that cycle.
- Arithmetic is modulo 2^MEM_WIDTH; wrap on overflow/underflow; no flags.
- Write port:
  - wr_valid_o = FIFO non-empty; wr_addr_o/wr_data_o come from the FIFO head.
  - A transfer happens when wr_valid_o and wr_ready_i are both 1; the entry is popped on that edge.
  - While wr_valid_o=1 and wr_ready_i=0, wr_addr_o/wr_data_o stay stable.
  - Push and pop in the same cycle are legal; occupancy is unchanged.
  - The FIFO never overflows, guaranteed by the credit rule.
- Timing with wr_ready_i held at 1 and start sampled at edge 0:
  - rd_en_o is high in cycles 1..N.
  - wr_valid_o is high in cycles 3..N+2.
  - done_o=1 in cycle N+3.
  - busy_o falls in cycle N+4.
  - Throughput is one element per cycle.

Decomposition:
- Package op_seq_pkg:
  - op_e enum (OP_ADD, OP_SUB, OP_AND, OP_XOR).
  - state_e enum (IDLE, RUN, DRAIN, DONE).
  - Function wrap_inc(addr, depth).
- Sub-module seq_result_fifo: 2-entry synchronous FIFO of {AW addr, MEM_WIDTH data}, with push/pop/occupancy outputs and the same clock/reset.

Test Plan:
- Basic add: all operand1=3, operand2=4, base=0, count=8, op=add, ready=1 -> writes addr 0..7 with data 7, in cycles 3..10; done_o in cycle 11 only.
- Wrap and sub: base=6, count=4, op=sub, op1=5, op2=9 -> addresses 6,7,0,1 in order, data 0xFFFFFFFC each.
- Zero count: count=0 -> no rd_en_o or wr_valid_o; done_o in cycle 1; busy_o high in cycle 1 only. Separately, count=12 -> exactly 8 writes.
- Backpressure: count=8, wr_ready_i=0 in cycles 3..7 -> at most 2 reads outstanding, wr_addr/wr_data stable while stalled, all 8 writes in order, no loss or duplicates.
- Boundary data: op1=0xFFFFFFFF, op2=1 with add -> 0x00000000. Same operands with xor -> 0xFFFFFFFE; with and -> 0x00000001.
- Reset/start misuse: rst_ni low in cycle 4 of a run -> all outputs 0 asynchronously, no done_o. A later start runs correctly. start_i pulsed mid-run is ignored; the write count equals the first request's count.
